pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined add/subtract unit with full valid/ready flow control on both sides; next generation of the team's synchronous adder.
- The operand width is split into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is registered between stages.
- Adds subtract mode, carry/borrow-in, signed-overflow flag and per-stage backpressure stalling.
- Sits between an upstream operand producer and a downstream result consumer; throughput is one operation per cycle.

Parameters:
- DATA_WIDTH, 16, operand/result width; must be divisible by STAGES (elaboration-time assertion).
- STAGES, 2, pipeline depth = number of carry chunks; range 1..DATA_WIDTH; latency in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_val  in  1  operand beat valid.
- in_rdy  out  1  unit can accept a beat this cycle.
- A  in  DATA_WIDTH  operand A.
- B  in  DATA_WIDTH  operand B.
- cin  in  1  add: carry-in; sub: borrow-in.
- sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- sgn  in  1  operands signed; affects saturation only.
- out_val  out  1  result valid.
- out_rdy  in  1  consumer accepts the result.
- S  out  DATA_WIDTH  result.
- C  out  1  add: carry-out; sub: borrow-out (inverted internal carry).
- V  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Transfer rules:
  - Input transfer occurs on a rising edge with in_val && in_rdy.
  - Output transfer occurs with out_val && out_rdy.
- Arithmetic:
  - sub=1 uses A + ~B + !cin.
  - Internal carry-out c; C = sub ? !c : c.
- Stage k (0..STAGES-1) register contents:
  - valid bit.
  - Sum bits [(k+1)*W-1 : 0], where W = DATA_WIDTH/STAGES.
  - Unconsumed upper chunks of A and ~B/B.
  - Carry out of chunk k.
  - Carry into chunk k (needed for V on the last stage).
  - sub and sgn.
- Stage k loads chunk k sum from its predecessor's carry. Stage 0 uses cin or !cin.
- Stall chain:
  - adv[STAGES-1] = !valid[STAGES-1] || out_rdy.
  - adv[k] = !valid[k] || adv[k+1].
  - in_rdy = adv[0] (combinational from out_rdy; no skid buffer).
- A stage holds its contents when !adv[k]. A bubble is written when a stage advances without new data from its predecessor.
- Latency: a beat accepted at edge t presents out_val=1 after edge t+STAGES if not stalled.
- Throughput: one beat per cycle with out_rdy held high.
- Ordering: strict FIFO; no beat is dropped or duplicated under any out_rdy pattern.
- S, C, V are driven from the last stage and are stable while out_val && !out_rdy.
- Reset:
  - All valid bits are cleared; out_val=0, S=0, C=0, V=0.
  - Data registers are cleared too.
  - Reset mid-operation discards all in-flight beats.
  - in_rdy=1 on the first cycle after reset release.
- Boundary case STAGES=1: single registered stage, latency 1.
- Boundary case STAGES=DATA_WIDTH: 1-bit chunks, full ripple pipeline.
- Simultaneous events: a full pipeline with out_rdy=1 accepts a new beat in the same cycle the last beat leaves.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- When defined, S is saturated in the final stage:
  - sgn=0, add with C=1: S = all-ones.
  - sgn=0, sub with C=1: S = 0.
  - sgn=1 with V=1: S = max positive if A's MSB=0, else min negative.
- C and V still report the raw unsaturated condition.
- When undefined: wrap-around result, no saturation logic present.

Decomposition:
- Package addsub_pkg holds:
  - Stage payload struct typedef (sum, rem operands, carry, sub, sgn).
  - Function returning chunk width W.
  - Saturation constants derived from DATA_WIDTH.
- One sub-module, addsub_stage: one chunk adder plus its registers and hold/advance logic, instantiated STAGES times in a generate loop.
- The top level holds the adv chain, the flag and saturation logic, and the output assigns.

Test Plan (DATA_WIDTH=8, STAGES=2):
- Unsigned add: A=0xF0, B=0x20, cin=0, sub=0 -> 2 cycles later S=0x10, C=1, V=0; with ADDSUB_SAT_EN and sgn=0, S=0xFF.
- Signed add: A=0x7F, B=0x01, sub=0 -> S=0x80, C=0, V=1; with ADDSUB_SAT_EN and sgn=1, S=0x7F.
- Subtract with borrow: A=0x10, B=0x20, cin=1, sub=1 -> S=0xEF, C=1, V=0; with ADDSUB_SAT_EN and sgn=0, S=0x00.
- Backpressure:
  - Stimulus: 6 back-to-back beats A=1..6, B=0, out_rdy=0 for cycles 0-5, then 1.
  - Response: in_rdy low after 2 beats are held.
  - Outputs 1..6 appear in order, none lost; S constant while stalled.
- Throughput: 10 back-to-back beats with out_rdy=1 -> out_val high on 10 consecutive cycles starting at cycle 2.
- Reset mid-flight: assert rst for 1 cycle while 2 beats are in flight -> out_val=0, S/C/V=0 the next cycle, in-flight beats never emerge, in_rdy=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// The pipe_addsub build option ADDSUB_SAT_EN (saturating result) does not affect this package.
package addsub_pkg;

  // Control payload that travels alongside each beat through the pipeline.
  // carry : carry out of the most recently added chunk (carry into the next one)
  // sub   : beat is a subtraction (B already inverted at the pipeline input)
  // sgn   : operands are two's-complement signed (only used for saturation)
  typedef struct packed {
    logic carry;
    logic sub;
    logic sgn;
  } stage_ctrl_t;

  // Width of one carry chunk for a given operand width and pipeline depth.
  function automatic int chunk_width(input int data_width, input int stages);
    return data_width / stages;
  endfunction

  // Largest positive two's-complement value: 0111...1 (as an int, for narrow widths).
  function automatic int sat_max_pos_int(input int data_width);
    return (data_width >= 2) ? ((32'sd1 <<< (data_width - 1)) - 32'sd1) : 32'sd0;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage of pipe_addsub: adds chunk INDEX of the operands using the
// carry registered by the previous stage, and holds or advances its registers
// according to the stall chain computed at the top level.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHUNK      = 8,
  parameter int INDEX      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sum,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  stage_ctrl_t           in_ctrl,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output stage_ctrl_t           out_ctrl
);

  logic [CHUNK:0]          chunk_res;
  logic [DATA_WIDTH-1:0]   sum_next;
  stage_ctrl_t             ctrl_next;

  // Add this stage's chunk and splice it into the partial sum from upstream.
  always_comb begin
    chunk_res = {1'b0, in_a[INDEX*CHUNK +: CHUNK]}
              + {1'b0, in_b[INDEX*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, in_ctrl.carry};
    sum_next = in_sum;
    sum_next[INDEX*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    ctrl_next.carry = chunk_res[CHUNK];
    ctrl_next.sub   = in_ctrl.sub;
    ctrl_next.sgn   = in_ctrl.sgn;
  end

  // Stage register: load on advance with data, write a bubble on advance without data, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_ctrl  <= '0;
    end else if (adv) begin
      if (in_valid) begin
        out_valid <= 1'b1;
        out_sum   <= sum_next;
        out_a     <= in_a;
        out_b     <= in_b;
        out_ctrl  <= ctrl_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit with valid/ready flow control on both sides.
// DATA_WIDTH is split into STAGES chunks; each chunk is added in its own
// stage with the carry registered in between, so latency is STAGES cycles.
// Build option: define ADDSUB_SAT_EN to saturate S in the final stage
// (C and V keep reporting the raw, unsaturated condition).
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  cin,
  input  logic                  sub,
  input  logic                  sgn,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  C,
  output logic                  V
);

  localparam int W   = chunk_width(DATA_WIDTH, STAGES);
  localparam int MSB = DATA_WIDTH - 1;

  generate
    if ((STAGES < 1) || (STAGES > DATA_WIDTH) || ((DATA_WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipe_addsub: DATA_WIDTH must be a multiple of STAGES and 1 <= STAGES <= DATA_WIDTH");
    end
  endgenerate

  // Index 0 is the pipeline input; index k+1 is the register output of stage k.
  logic                  val_a  [0:STAGES];
  logic [DATA_WIDTH-1:0] sum_a  [0:STAGES];
  logic [DATA_WIDTH-1:0] a_a    [0:STAGES];
  logic [DATA_WIDTH-1:0] b_a    [0:STAGES];
  stage_ctrl_t           ctrl_a [0:STAGES];

  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     adv;

  logic                  c_raw;
  logic                  c_into_msb;
  logic [DATA_WIDTH-1:0] s_mux;

  // Subtraction is A + ~B + !cin, so B and the stage-0 carry are conditioned here.
  always_comb begin
    val_a[0]        = in_val;
    sum_a[0]        = '0;
    a_a[0]          = A;
    b_a[0]          = sub ? ~B : B;
    ctrl_a[0].carry = sub ? ~cin : cin;
    ctrl_a[0].sub   = sub;
    ctrl_a[0].sgn   = sgn;
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      addsub_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHUNK      (W),
        .INDEX      (k)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv[k]),
        .in_valid  (val_a[k]),
        .in_sum    (sum_a[k]),
        .in_a      (a_a[k]),
        .in_b      (b_a[k]),
        .in_ctrl   (ctrl_a[k]),
        .out_valid (val_a[k+1]),
        .out_sum   (sum_a[k+1]),
        .out_a     (a_a[k+1]),
        .out_b     (b_a[k+1]),
        .out_ctrl  (ctrl_a[k+1])
      );
      assign vld[k] = val_a[k+1];
    end
  endgenerate

  // Stall chain: a stage may advance if the consumer takes the result or any
  // stage at or after it holds a bubble that can absorb the shift.
  always_comb begin
    adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      adv[i] = out_rdy;
      for (int j = i; j < STAGES; j++) begin
        if (!vld[j]) begin
          adv[i] = 1'b1;
        end else begin
          adv[i] = adv[i];
        end
      end
    end
  end

  assign in_rdy = adv[0];

  // Raw flags from the last stage: carry into the MSB is recovered from a ^ b ^ sum.
  always_comb begin
    c_raw      = ctrl_a[STAGES].carry;
    c_into_msb = a_a[STAGES][MSB] ^ b_a[STAGES][MSB] ^ sum_a[STAGES][MSB];
  end

`ifdef ADDSUB_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX_POS = DATA_WIDTH'(sat_max_pos_int(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN_NEG = ~SAT_MAX_POS;

  // Saturate the final result; unsigned uses carry/borrow, signed uses overflow.
  always_comb begin
    s_mux = sum_a[STAGES];
    if (!ctrl_a[STAGES].sgn && (ctrl_a[STAGES].sub ? ~c_raw : c_raw)) begin
      s_mux = ctrl_a[STAGES].sub ? '0 : '1;
    end else if (ctrl_a[STAGES].sgn && (c_into_msb ^ c_raw)) begin
      s_mux = a_a[STAGES][MSB] ? SAT_MIN_NEG : SAT_MAX_POS;
    end else begin
      s_mux = sum_a[STAGES];
    end
  end
`else
  // Wrap-around result straight from the last stage register.
  always_comb begin
    s_mux = sum_a[STAGES];
  end
`endif

  assign out_val = val_a[STAGES];
  assign S       = s_mux;
  assign C       = ctrl_a[STAGES].sub ? ~c_raw : c_raw;
  assign V       = c_into_msb ^ c_raw;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (DATA_WIDTH=8, STAGES=2).
// Honours ADDSUB_SAT_EN when the build defines it.
module tb_pipe_addsub;

  localparam int DW = 8;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic          in_rdy;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          cin;
  logic          sub;
  logic          sgn;
  logic          out_val;
  logic          out_rdy;
  logic [DW-1:0] S;
  logic          C;
  logic          V;

  pipe_addsub #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
    .A(A), .B(B), .cin(cin), .sub(sub), .sgn(sgn),
    .out_val(out_val), .out_rdy(out_rdy), .S(S), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] s;
    logic          c;
    logic          v;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_out = 0;

  logic          smp_out_val, smp_in_rdy, smp_in_fire;
  logic [DW-1:0] smp_s;
  logic          smp_c, smp_v;
  logic          stall_prev = 1'b0;
  logic [DW+1:0] held;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic ci, input logic sb, input logic sg);
    exp_t e;
    int   u, sv;
    int   sa, sbb;
    sa  = $signed(a);
    sbb = $signed(b);
    if (!sb) begin
      u  = int'(a) + int'(b) + int'(ci);
      sv = sa + sbb + int'(ci);
      e.c = (u > 255);
    end else begin
      u  = int'(a) - int'(b) - int'(ci);
      sv = sa - sbb - int'(ci);
      e.c = (u < 0);
    end
    e.s = u[DW-1:0];
    e.v = (sv > 127) || (sv < -128);
`ifdef ADDSUB_SAT_EN
    if (!sg && e.c) e.s = sb ? 8'h00 : 8'hFF;
    else if (sg && e.v) e.s = a[DW-1] ? 8'h80 : 8'h7F;
`else
    if (sg) e.s = e.s;
`endif
    e.cyc = 0;
    return e;
  endfunction

  // One clock cycle: sample on the falling edge, score transfers, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    smp_out_val = out_val;
    smp_in_rdy  = in_rdy;
    smp_s = S; smp_c = C; smp_v = V;
    smp_in_fire = 1'b0;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check_val("hold", {out_val, S, C, V}, {1'b1, held});
      if (out_val && out_rdy) begin
        n_out++;
        if (q.size() == 0) begin
          check_val("spurious_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check_val("result", {S, C, V}, {e.s, e.c, e.v});
          check_val("latency_min", 32'(cyc - e.cyc >= ST), 32'd1);
        end
      end
      if (in_val && in_rdy) begin
        smp_in_fire = 1'b1;
        e = model(A, B, cin, sub, sgn);
        e.cyc = cyc;
        q.push_back(e);
      end
      stall_prev = out_val && !out_rdy;
      held = {S, C, V};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    in_val = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() != 0 || out_val) step();
    end
    check_val("drained", 32'(q.size()), 32'd0);
  endtask

  task automatic directed(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci,
                          input logic sb, input logic sg, input logic [DW-1:0] es,
                          input logic ec, input logic ev);
    out_rdy = 1'b1;
    in_val = 1'b1; A = a; B = b; cin = ci; sub = sb; sgn = sg;
    step();
    in_val = 1'b0;
    step();
    check_val("dir_early", 32'(smp_out_val), 32'd0);
    step();
    check_val("dir_valid", 32'(smp_out_val), 32'd1);
    check_val("dir_scv", {smp_s, smp_c, smp_v}, {es, ec, ev});
  endtask

  initial begin
    int            nxt;
    int            out0;
    logic [15:0]   mask;
    logic          all_rdy;
    rst = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0; sgn = 1'b0;
    step(); step();
    check_val("rst_state", {out_val, S, C, V}, 32'd0);
    rst = 1'b0;
    step();
    check_val("rst_in_rdy", 32'(smp_in_rdy), 32'd1);
    check_val("rst_out_val", 32'(smp_out_val), 32'd0);

    // Directed vectors from the test plan.
`ifdef ADDSUB_SAT_EN
    directed(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    directed(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    directed(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
`else
    directed(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0);
    directed(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    directed(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 8'hEF, 1'b1, 1'b0);
`endif
    drain();

    // Backpressure: consumer stalled for 6 cycles, six beats offered back to back.
    out0 = n_out;
    nxt = 1;
    for (int i = 0; i < 40 && (nxt <= 6 || q.size() != 0); i++) begin
      out_rdy = (i >= 6);
      in_val = (nxt <= 6);
      A = 8'(nxt); B = 8'h00; cin = 1'b0; sub = 1'b0; sgn = 1'b0;
      step();
      if (smp_in_fire) nxt++;
      if (i == 2) check_val("bp_in_rdy_low", 32'(smp_in_rdy), 32'd0);
      if (i == 5) check_val("bp_accepted", 32'(nxt - 1), 32'd2);
    end
    drain();
    check_val("bp_count", 32'(n_out - out0), 32'd6);

    // Throughput: ten beats with the consumer always ready.
    mask = '0;
    all_rdy = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_val = (i < 10);
      A = 8'($urandom); B = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom); sgn = 1'($urandom);
      step();
      mask[i] = smp_out_val;
      if (!smp_in_rdy) all_rdy = 1'b0;
    end
    check_val("tput_out_val_mask", 32'(mask), 32'h0FFC);
    check_val("tput_in_rdy", 32'(all_rdy), 32'd1);
    drain();

    // Reset with two beats in flight.
    out_rdy = 1'b1;
    in_val = 1'b1; A = 8'h11; B = 8'h01; cin = 1'b0; sub = 1'b0; sgn = 1'b0;
    step();
    A = 8'h22;
    step();
    in_val = 1'b0; out_rdy = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    out_rdy = 1'b1;
    out0 = n_out;
    step();
    check_val("midrst_outputs", {smp_out_val, smp_s, smp_c, smp_v}, 32'd0);
    check_val("midrst_in_rdy", 32'(smp_in_rdy), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check_val("midrst_no_emerge", 32'(n_out - out0), 32'd0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 9) < 7);
      A = 8'($urandom); B = 8'($urandom);
      cin = 1'($urandom); sub = 1'($urandom); sgn = 1'($urandom);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
